// File: rtl/rx_serial_7o1.sv
// 7O1 asynchronous serial receiver: 7 data bits LSB first, odd parity, one stop bit.
// Holds each character until the consumer strobes recebe_dado and flags parity, framing and overrun errors.
module rx_serial_7o1 #(
  parameter int BIT_CYCLES = 434,
  parameter int N          = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  input  logic       recebe_dado,
  output logic [6:0] dados_ascii,
  output logic       pronto,
  output logic       tem_dado,
  output logic       erro_paridade,
  output logic       erro_parada,
  output logic       erro_overrun,
  output logic [3:0] db_estado,
  output logic       db_recebendo
);

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    START    = 4'd1,
    DADOS    = 4'd2,
    PARIDADE = 4'd3,
    PARADA   = 4'd4,
    FINAL    = 4'd5
  } state_t;

  localparam logic [N-1:0] HALF_LAST = N'(BIT_CYCLES / 2 - 1);
  localparam logic [N-1:0] FULL_LAST = N'(BIT_CYCLES - 1);

  state_t state, next_state;

  logic         sync1, sync2;
  logic [N-1:0] count;
  logic [2:0]   bit_count;
  logic [6:0]   shift;
  logic         parity_bit, stop_bit;
  logic         armed;
  logic         tick_half, tick_full;

  assign tick_half = (count == HALF_LAST);
  assign tick_full = (count == FULL_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= entrada_serial;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= INICIAL;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      INICIAL:  if (armed && !sync2) next_state = START;
      START:    if (tick_half) next_state = sync2 ? INICIAL : DADOS;
      DADOS:    if (tick_full && bit_count == 3'd6) next_state = PARIDADE;
      PARIDADE: if (tick_full) next_state = PARADA;
      PARADA:   if (tick_full) next_state = FINAL;
      FINAL:    next_state = INICIAL;
      default:  next_state = INICIAL;
    endcase
  end

  // armed only goes high after the line has been seen idle in INICIAL, so a held break cannot restart a frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      bit_count  <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      stop_bit   <= 1'b0;
      armed      <= 1'b0;
    end else begin
      armed <= (state == INICIAL) && sync2;
      case (state)
        INICIAL: begin
          count     <= '0;
          bit_count <= '0;
        end
        START: count <= tick_half ? '0 : count + 1'b1;
        DADOS: begin
          if (tick_full) begin
            count     <= '0;
            shift     <= {sync2, shift[6:1]};
            bit_count <= bit_count + 3'd1;
          end else begin
            count <= count + 1'b1;
          end
        end
        PARIDADE: begin
          if (tick_full) begin
            count      <= '0;
            parity_bit <= sync2;
          end else begin
            count <= count + 1'b1;
          end
        end
        PARADA: begin
          if (tick_full) begin
            count    <= '0;
            stop_bit <= sync2;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: count <= '0;
      endcase
    end
  end

  // a completing frame takes priority over a simultaneous consume strobe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dados_ascii   <= '0;
      pronto        <= 1'b0;
      tem_dado      <= 1'b0;
      erro_paridade <= 1'b0;
      erro_parada   <= 1'b0;
      erro_overrun  <= 1'b0;
    end else begin
      pronto <= (state == FINAL);
      if (state == FINAL) begin
        dados_ascii   <= shift;
        erro_paridade <= ~^{shift, parity_bit};
        erro_parada   <= ~stop_bit;
        tem_dado      <= 1'b1;
        erro_overrun  <= recebe_dado ? 1'b0 : (erro_overrun | tem_dado);
      end else if (recebe_dado) begin
        tem_dado     <= 1'b0;
        erro_overrun <= 1'b0;
      end
    end
  end

  assign db_estado    = state;
  assign db_recebendo = (state != INICIAL);

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Self-checking bench for rx_serial_7o1: frame-level reference model with a per-cycle compare process,
// directed scenarios plus randomized frames.
module tb_rx_serial_7o1;

  localparam int BIT = 434;
  localparam int DUE = 9 * BIT + BIT / 2 + 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       entrada_serial = 1'b1;
  logic       recebe_dado = 1'b0;
  logic [6:0] dados_ascii;
  logic       pronto, tem_dado, erro_paridade, erro_parada, erro_overrun;
  logic [3:0] db_estado;
  logic       db_recebendo;

  rx_serial_7o1 #(.BIT_CYCLES(BIT), .N(9)) dut (
    .clock(clock), .reset(reset), .entrada_serial(entrada_serial), .recebe_dado(recebe_dado),
    .dados_ascii(dados_ascii), .pronto(pronto), .tem_dado(tem_dado), .erro_paridade(erro_paridade),
    .erro_parada(erro_parada), .erro_overrun(erro_overrun), .db_estado(db_estado),
    .db_recebendo(db_recebendo)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clock) cyc++;

  always @(posedge clock) begin
    if (cyc > 90000) begin
      $display("[TB] FAIL watchdog cycle=%0d limit=90000", cyc);
      $fatal(1, "[TB] watchdog expired");
    end
  end

  typedef struct {
    logic [6:0] data;
    logic       perr;
    logic       serr;
    int         due;
  } frame_t;

  frame_t     exp_q[$];
  logic [6:0] m_data = '0;
  logic       m_perr = 1'b0, m_serr = 1'b0, m_tem = 1'b0, m_ovr = 1'b0;
  logic       rcv_at_edge = 1'b0;

  function automatic logic odd_parity(input logic [6:0] d);
    return ~^d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clock) rcv_at_edge = recebe_dado;

  // Reference model: frames announced by the driver, consumed when pronto shows up in their time window
  always @(negedge clock) begin
    frame_t f;
    if (!reset) begin
      exp_q.delete();
      m_data = '0; m_perr = 0; m_serr = 0; m_tem = 0; m_ovr = 0;
      check("rst_dados", dados_ascii, 0);
      check("rst_pronto", pronto, 0);
      check("rst_tem_dado", tem_dado, 0);
      check("rst_erro_paridade", erro_paridade, 0);
      check("rst_erro_parada", erro_parada, 0);
      check("rst_erro_overrun", erro_overrun, 0);
      check("rst_db_estado", db_estado, 0);
      check("rst_db_recebendo", db_recebendo, 0);
    end else begin
      if (pronto) begin
        check("pronto_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          f = exp_q.pop_front();
          check("pronto_time", cyc, f.due);
          m_data = f.data;
          m_perr = f.perr;
          m_serr = f.serr;
        end
        m_ovr = rcv_at_edge ? 1'b0 : (m_ovr | m_tem);
        m_tem = 1'b1;
      end else if (rcv_at_edge) begin
        m_tem = 1'b0;
        m_ovr = 1'b0;
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].due + 2) begin
        checks++;
        errors++;
        $display("[TB] FAIL pronto_missing actual=none required=cycle %0d", exp_q[0].due);
        exp_q.delete(0);
      end
      check("dados_ascii", dados_ascii, m_data);
      check("erro_paridade", erro_paridade, m_perr);
      check("erro_parada", erro_parada, m_serr);
      check("tem_dado", tem_dado, m_tem);
      check("erro_overrun", erro_overrun, m_ovr);
      check("db_recebendo", db_recebendo, db_estado != 4'd0);
    end
  end

  task automatic hold_line(input logic v, input int n);
    entrada_serial = v;
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic pulse_recebe();
    recebe_dado = 1'b1;
    @(posedge clock);
    #2;
    recebe_dado = 1'b0;
  endtask

  task automatic applyStimulus(input logic [6:0] d, input logic p, input logic s);
    logic [8:0] bits;
    bits = {s, p, d};
    @(posedge clock);
    #2;
    entrada_serial = 1'b0;
    exp_q.push_back('{d, ~^{d, p}, ~s, cyc + DUE});
    for (int i = 0; i < 9; i++) begin
      repeat (BIT) @(posedge clock);
      #2;
      entrada_serial = bits[i];
    end
    repeat (BIT) @(posedge clock);
    #2;
  endtask

  task automatic checkOutput(input logic [6:0] d, input logic t, input logic pe, input logic se,
                             input logic ov);
    check("lit_dados", dados_ascii, d);
    check("lit_tem_dado", tem_dado, t);
    check("lit_erro_paridade", erro_paridade, pe);
    check("lit_erro_parada", erro_parada, se);
    check("lit_erro_overrun", erro_overrun, ov);
  endtask

  initial begin
    logic [6:0] d;
    logic       p, s;
    int         gap;

    #1 reset = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    hold_line(1'b1, 20);

    $display("[TB] good frame 0x23");
    check("parity_model_23", odd_parity(7'h23), 0);
    applyStimulus(7'h23, 1'b0, 1'b1);
    checkOutput(7'h23, 1, 0, 0, 0);
    pulse_recebe();
    check("lit_consumed", tem_dado, 0);

    $display("[TB] parity error frame 0x35");
    check("parity_model_35", odd_parity(7'h35), 1);
    applyStimulus(7'h35, 1'b0, 1'b1);
    checkOutput(7'h35, 1, 1, 0, 0);
    pulse_recebe();

    $display("[TB] framing error and held break");
    applyStimulus(7'h23, 1'b0, 1'b0);
    hold_line(1'b0, 600);
    check("lit_break_idle", db_estado, 0);
    checkOutput(7'h23, 1, 0, 1, 0);
    hold_line(1'b1, 20);

    $display("[TB] glitch on idle line");
    hold_line(1'b0, 50);
    check("lit_glitch_start", db_estado, 1);
    hold_line(1'b0, 50);
    hold_line(1'b1, 300);
    check("lit_glitch_back", db_estado, 0);
    check("lit_glitch_tem", tem_dado, 1);
    pulse_recebe();

    $display("[TB] back-to-back overrun");
    applyStimulus(7'h31, odd_parity(7'h31), 1'b1);
    applyStimulus(7'h32, odd_parity(7'h32), 1'b1);
    checkOutput(7'h32, 1, 0, 0, 1);
    pulse_recebe();
    check("lit_ovr_cleared", erro_overrun, 0);
    check("lit_tem_cleared", tem_dado, 0);

    $display("[TB] consume on completion cycle");
    applyStimulus(7'h41, odd_parity(7'h41), 1'b1);
    fork
      applyStimulus(7'h42, odd_parity(7'h42), 1'b1);
      begin
        int w;
        w = 0;
        while (db_estado != 4'd5 && w < 6000) begin
          @(negedge clock);
          w++;
        end
        if (w >= 6000) begin
          checks++;
          errors++;
          $display("[TB] FAIL final_wait actual=timeout required=state 5");
        end else begin
          recebe_dado = 1'b1;
          @(posedge clock);
          #2 recebe_dado = 1'b0;
        end
      end
    join
    checkOutput(7'h42, 1, 0, 0, 0);
    pulse_recebe();

    $display("[TB] reset in the middle of a frame");
    @(posedge clock);
    #2 entrada_serial = 1'b0;
    hold_line(1'b0, 4 * BIT + 100);
    check("lit_in_dados", db_estado, 2);
    reset = 1'b0;
    hold_line(1'b1, 5);
    reset = 1'b1;
    hold_line(1'b1, 20);
    applyStimulus(7'h23, 1'b0, 1'b1);
    checkOutput(7'h23, 1, 0, 0, 0);
    pulse_recebe();

    $display("[TB] randomized frames");
    for (int k = 0; k < 4; k++) begin
      d = 7'($urandom_range(0, 127));
      p = ($urandom_range(0, 3) == 0) ? ~odd_parity(d) : odd_parity(d);
      s = ($urandom_range(0, 4) != 0);
      applyStimulus(d, p, s);
      if ($urandom_range(0, 1) == 1) pulse_recebe();
      gap = s ? $urandom_range(0, 300) : $urandom_range(20, 300);
      hold_line(1'b1, gap);
    end

    hold_line(1'b1, 50);
    check("frames_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
